// File: rtl/instr_loader.sv
// Program loader: assembles UART byte pairs into 16-bit instruction words and
// writes them to instruction memory, holding the CPU until a clean end marker.
module instr_loader #(
    parameter int          ADDR_W   = 8,
    parameter logic [15:0] END_WORD = 16'hFFFF,
    parameter int          TIMEOUT  = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [15:0]       o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W:0]   o_word_count
);

    localparam int GAP_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_HI, S_WAIT_LO, S_WRITE, S_DONE, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       word;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        gap_d   = gap_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        word    = {hi_q, i_rx_data};

        // A start pulse restarts from any state and drops any byte strobed with it
        if (i_start) begin
            state_d = S_WAIT_HI;
            addr_d  = '0;
            cnt_d   = '0;
            gap_d   = '0;
            hold_d  = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_WAIT_HI: begin
                    if (i_rx_valid) begin
                        hi_d    = i_rx_data;
                        gap_d   = '0;
                        state_d = S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (i_rx_valid) begin
                        if (word == END_WORD) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            hold_d  = 1'b0;
                        end else if (word[15:12] > 4'hA || cnt_q == FULL) begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            hold_d  = 1'b1;
                        end else begin
                            state_d = S_WRITE;
                            we_d    = 1'b1;
                            waddr_d = addr_q;
                            wdata_d = word;
                        end
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                        if (gap_d == GAP_W'(TIMEOUT)) begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                            busy_d  = 1'b0;
                            hold_d  = 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = (cnt_q == FULL) ? cnt_q : cnt_q + (ADDR_W+1)'(1);
                    // A byte arriving alongside the write pulse is the next high byte
                    if (i_rx_valid) begin
                        hi_d    = i_rx_data;
                        gap_d   = '0;
                        state_d = S_WAIT_LO;
                    end else begin
                        state_d = S_WAIT_HI;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            gap_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            gap_q   <= gap_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_imem_we    = we_q;
    assign o_imem_addr  = waddr_q;
    assign o_imem_wdata = wdata_q;
    assign o_cpu_hold   = hold_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_word_count = cnt_q;

endmodule
